// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial-bit sequence detector.
// Accepts a run descriptor, scores overlapping matches, and reports how the run ended.
`timescale 1ns/1ps
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TMO_W-1:0]   cfg_timeout,
    input  logic               a,
    input  logic               a_valid,
    input  logic               abort,
    output logic               busy,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic [1:0]         status
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [MAX_LEN-1:0] pattern_r;
    logic [MAX_LEN-1:0] hist_r;
    logic [3:0]         len_r;
    logic [3:0]         fill_r;
    logic [CNT_W-1:0]   target_r;
    logic [TMO_W-1:0]   timeout_r;
    logic [TMO_W-1:0]   cyc_r;

    logic [MAX_LEN-1:0] hist_next_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [3:0]         fill_next_s;
    logic [CNT_W-1:0]   count_inc_s;
    logic               match_s;
    logic               tgt_hit_s;
    logic               tmo_hit_s;
    logic               len_bad_s;

    // Next history/fill and the match/exit conditions for the current RUN edge
    always_comb begin
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (4'(i) < len_r);
        end
        if (a_valid) begin
            hist_next_s = {hist_r[MAX_LEN-2:0], a};
            fill_next_s = (fill_r < len_r) ? (fill_r + 4'd1) : fill_r;
        end else begin
            hist_next_s = hist_r;
            fill_next_s = fill_r;
        end
        // Only a freshly sampled bit can complete a match, otherwise a stalled
        // stream would re-score the same history every cycle.
        match_s = a_valid && (fill_next_s >= len_r) &&
                  ((hist_next_s & mask_s) == (pattern_r & mask_s));
        count_inc_s = (match_count == {CNT_W{1'b1}}) ? match_count : (match_count + CNT_W'(1));
        tgt_hit_s = (target_r != {CNT_W{1'b0}}) && match_s && (count_inc_s == target_r);
        tmo_hit_s = (timeout_r != {TMO_W{1'b0}}) && (cyc_r == (timeout_r - TMO_W'(1)));
        len_bad_s = (len_r == 4'd0) || (len_r > 4'(MAX_LEN));
    end

    // Run-control FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pattern_r   <= {MAX_LEN{1'b0}};
            hist_r      <= {MAX_LEN{1'b0}};
            len_r       <= 4'd0;
            fill_r      <= 4'd0;
            target_r    <= {CNT_W{1'b0}};
            timeout_r   <= {TMO_W{1'b0}};
            cyc_r       <= {TMO_W{1'b0}};
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
            detected    <= 1'b0;
            match_count <= {CNT_W{1'b0}};
            done        <= 1'b0;
            status      <= 2'b00;
        end else begin
            detected <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        pattern_r   <= cfg_pattern;
                        len_r       <= cfg_len;
                        target_r    <= cfg_target;
                        timeout_r   <= cfg_timeout;
                        match_count <= {CNT_W{1'b0}};
                        status      <= 2'b00;
                        cfg_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    hist_r      <= {MAX_LEN{1'b0}};
                    fill_r      <= 4'd0;
                    cyc_r       <= {TMO_W{1'b0}};
                    match_count <= {CNT_W{1'b0}};
                    if (abort) begin
                        status  <= 2'b11;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else if (len_bad_s) begin
                        status  <= 2'b00;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    hist_r <= hist_next_s;
                    fill_r <= fill_next_s;
                    cyc_r  <= cyc_r + TMO_W'(1);
                    if (match_s) begin
                        detected    <= 1'b1;
                        match_count <= count_inc_s;
                    end
                    if (abort || tgt_hit_s || tmo_hit_s) begin
                        status  <= abort ? 2'b11 : (tgt_hit_s ? 2'b01 : 2'b10);
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed and random runs scored
// against a bit-queue reference model of the detection rules.
`timescale 1ns/1ps
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_timeout;
    logic        a;
    logic        a_valid;
    logic        abort;
    logic        busy;
    logic        detected;
    logic [7:0]  match_count;
    logic        done;
    logic [1:0]  status;

    int total = 0;
    int bad   = 0;

    logic stim_a [0:511];
    logic stim_v [0:511];
    int   abort_at;

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8), .TMO_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
        .a(a), .a_valid(a_valid), .abort(abort),
        .busy(busy), .detected(detected), .match_count(match_count),
        .done(done), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_stream(input logic [23:0] bits);
        for (int i = 0; i < 512; i++) begin
            stim_a[i] = (i < 24) ? bits[23 - i] : 1'b0;
            stim_v[i] = 1'b1;
        end
    endtask

    // Issue one descriptor and follow the run cycle by cycle against the model.
    // stop_after >= 0 leaves the run in progress after that many RUN cycles.
    task automatic do_run(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt,
                          input logic [15:0] tmo, input int stop_after, input string name);
        bit q[$];
        int cnt;
        int k;
        int w;
        int exp_st;
        bit ended;
        bit m;
        cnt = 0; k = 0; w = 0; exp_st = 0; ended = 1'b0;
        while (cfg_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk({name, "_ready"}, cfg_ready, 1);
        cfg_pattern = pat; cfg_len = len; cfg_target = tgt; cfg_timeout = tmo;
        cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0; a_valid = 1'b0; abort = 1'b0;
        chk({name, "_load_busy"}, busy, 1);
        chk({name, "_load_rdy"}, cfg_ready, 0);
        if (len == 4'd0 || len > 4'd8) begin
            @(posedge clk); #1;
            chk({name, "_err_done"}, done, 1);
            chk({name, "_err_status"}, status, 0);
            chk({name, "_err_count"}, match_count, 0);
            @(posedge clk); #1;
            chk({name, "_err_ready"}, cfg_ready, 1);
            chk({name, "_err_busy"}, busy, 0);
            chk({name, "_err_done_low"}, done, 0);
            return;
        end
        @(posedge clk); #1;
        chk({name, "_run_done"}, done, 0);
        while (!ended && k < 1000) begin
            if (stop_after >= 0 && k == stop_after) return;
            a = stim_a[k % 512];
            a_valid = stim_v[k % 512];
            abort = (k == abort_at);
            m = 1'b0;
            if (a_valid) begin
                q.push_back(a);
                if (q.size() >= int'(len)) begin
                    m = 1'b1;
                    for (int j = 0; j < int'(len); j++)
                        if (q[q.size() - 1 - j] != pat[j]) m = 1'b0;
                end
            end
            if (m && cnt < 255) cnt++;
            if (abort) begin
                ended = 1'b1; exp_st = 3;
            end else if (tgt != 8'd0 && m && cnt == int'(tgt)) begin
                ended = 1'b1; exp_st = 1;
            end else if (tmo != 16'd0 && k == int'(tmo) - 1) begin
                ended = 1'b1; exp_st = 2;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            chk({name, "_det"}, detected, m);
            chk({name, "_count"}, match_count, cnt);
            chk({name, "_done"}, done, ended);
            if (ended) chk({name, "_status"}, status, exp_st);
            k++;
        end
        a_valid = 1'b0;
        if (!ended) begin
            chk({name, "_bound"}, 0, 1);
            return;
        end
        @(posedge clk); #1;
        chk({name, "_idle_ready"}, cfg_ready, 1);
        chk({name, "_idle_busy"}, busy, 0);
        chk({name, "_idle_done"}, done, 0);
        chk({name, "_idle_det"}, detected, 0);
        chk({name, "_hold_status"}, status, exp_st);
        chk({name, "_hold_count"}, match_count, cnt);
    endtask

    initial begin
        logic [7:0] rp;
        logic [3:0] rl;
        logic [7:0] rt;
        logic [15:0] rto;
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_pattern = 8'd0; cfg_len = 4'd0;
        cfg_target = 8'd0; cfg_timeout = 16'd0; a = 1'b0; a_valid = 1'b0; abort = 1'b0;
        abort_at = -1;
        #12;
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_det", detected, 0);
        chk("rst_done", done, 0);
        chk("rst_count", match_count, 0);
        chk("rst_status", status, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        load_stream(24'b0011_0101_1001_1001_1010_1000);
        do_run(8'b0011_0011, 4'd6, 8'd2, 16'd0, -1, "p110011_tgt");
        do_run(8'b0000_1010, 4'd4, 8'd0, 16'd24, -1, "p1010_tmo");

        // Valid bits 1,0,1,0 on even cycles; odd cycles carry unsampled noise
        for (int i = 0; i < 512; i++) begin
            stim_v[i] = (i % 2 == 0);
            stim_a[i] = (i % 2 == 1) ? (i % 4 == 1) : ((i < 8) ? (i % 4 == 0) : 1'b0);
        end
        do_run(8'b0000_1010, 4'd4, 8'd0, 16'd20, -1, "alt_valid");

        for (int i = 0; i < 512; i++) begin
            stim_a[i] = 1'b1; stim_v[i] = 1'b1;
        end
        abort_at = 300;
        do_run(8'b0000_0011, 4'd2, 8'd0, 16'd0, -1, "saturate");
        abort_at = 3;
        do_run(8'b0000_0011, 4'd2, 8'd3, 16'd0, -1, "abort_vs_tgt");
        abort_at = -1;
        do_run(8'b0000_0011, 4'd2, 8'd3, 16'd0, -1, "tgt_only");

        do_run(8'hff, 4'd0, 8'd1, 16'd5, -1, "len0");
        do_run(8'hff, 4'd9, 8'd1, 16'd5, -1, "len9");

        for (int it = 0; it < 8; it++) begin
            rp = 8'($urandom);
            rl = 4'($urandom_range(2, 8));
            rt = 8'($urandom_range(0, 3));
            rto = 16'($urandom_range(20, 60));
            for (int i = 0; i < 512; i++) begin
                stim_a[i] = 1'($urandom);
                stim_v[i] = ($urandom_range(0, 3) != 0);
            end
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 19)) : -1;
            do_run(rp, rl, rt, rto, -1, "random");
        end
        abort_at = -1;

        for (int i = 0; i < 512; i++) begin
            stim_a[i] = 1'b1; stim_v[i] = 1'b1;
        end
        do_run(8'b0000_0011, 4'd2, 8'd0, 16'd0, 10, "pre_reset");
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", cfg_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_det", detected, 0);
        chk("mid_rst_count", match_count, 0);
        chk("mid_rst_status", status, 0);
        @(posedge clk); #1;
        chk("mid_rst_done", done, 0);
        rst_n = 1'b1;
        a_valid = 1'b0;
        load_stream(24'b0011_0101_1001_1001_1010_1000);
        do_run(8'b0000_1010, 4'd4, 8'd2, 16'd0, -1, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
